// File: rtl/wavelet_scale_engine_if.sv
// rtl/wavelet_scale_engine_if.sv - sample, control and result signals of the wavelet scale engine
interface wavelet_scale_engine_if #(
    parameter int BITS_PER_ELEM  = 8,
    parameter int NUM_SCALES     = 4,
    parameter int SUM_TRUNCATION = 8
);
    logic signed [BITS_PER_ELEM-1:0] i_value;
    logic                            i_data_clk;
    logic [NUM_SCALES-1:0]           i_enable_mask;
    logic                            i_decimate;
    logic [7:0]                      i_select_output_channel;
    logic [SUM_TRUNCATION-1:0]       o_multiplexed_wavelet_out;
    logic                            o_valid;
    logic                            o_busy;
    logic                            o_overrun;
    logic                            o_active;

    modport master (
        output i_value, i_data_clk, i_enable_mask, i_decimate, i_select_output_channel,
        input  o_multiplexed_wavelet_out, o_valid, o_busy, o_overrun, o_active
    );

    modport slave (
        input  i_value, i_data_clk, i_enable_mask, i_decimate, i_select_output_channel,
        output o_multiplexed_wavelet_out, o_valid, o_busy, o_overrun, o_active
    );
endinterface

// File: rtl/wavelet_scale_engine.sv
// rtl/wavelet_scale_engine.sv - multi-scale rolling average with a time-shared wavelet FIR MAC
module wavelet_scale_engine #(
    parameter int                          BITS_PER_ELEM  = 8,
    parameter int                          NUM_SCALES     = 4,
    parameter int                          FIR_NUM_ELEM   = 9,
    parameter logic [8*FIR_NUM_ELEM-1:0]   FILTER_VAL     = 72'hf6dcc51c7c1cc5dcf6,
    parameter int                          ACC_BITS       = 20,
    parameter int                          FIR_SHIFT      = 8,
    parameter int                          SUM_TRUNCATION = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    wavelet_scale_engine_if.slave  bus
);
    localparam int HIST_LEN       = 2 ** NUM_SCALES;
    localparam int RS_BITS        = BITS_PER_ELEM + NUM_SCALES + 1;
    localparam int PROD_BITS      = BITS_PER_ELEM + 8;
    localparam int TAP_IDX_BITS   = $clog2(FIR_NUM_ELEM);
    localparam int SCALE_IDX_BITS = (NUM_SCALES > 1) ? $clog2(NUM_SCALES) : 1;

    localparam logic [SCALE_IDX_BITS-1:0] LAST_SCALE = SCALE_IDX_BITS'(NUM_SCALES - 1);
    localparam logic [TAP_IDX_BITS-1:0]   LAST_TAP   = TAP_IDX_BITS'(FIR_NUM_ELEM - 1);
    localparam logic signed [ACC_BITS-1:0] SAT_MAX   = ACC_BITS'((1 <<< (SUM_TRUNCATION - 1)) - 1);
    localparam logic signed [ACC_BITS-1:0] SAT_MIN   = ~SAT_MAX;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_UPDATE = 3'd1;
    localparam logic [2:0] ST_MAC    = 3'd2;
    localparam logic [2:0] ST_STORE  = 3'd3;
    localparam logic [2:0] ST_SKIP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    logic [2:0]                       sync_q, sync_d;
    logic [2:0]                       state_q, state_d;
    logic [SCALE_IDX_BITS-1:0]        scale_q, scale_d;
    logic [TAP_IDX_BITS-1:0]          tap_idx_q, tap_idx_d;
    logic signed [BITS_PER_ELEM-1:0]  sample_q, sample_d;
    logic signed [BITS_PER_ELEM-1:0]  hist_q [HIST_LEN];
    logic signed [BITS_PER_ELEM-1:0]  hist_d [HIST_LEN];
    logic signed [RS_BITS-1:0]        rs_q [NUM_SCALES];
    logic signed [RS_BITS-1:0]        rs_d [NUM_SCALES];
    logic signed [BITS_PER_ELEM-1:0]  avg_q [NUM_SCALES];
    logic signed [BITS_PER_ELEM-1:0]  avg_d [NUM_SCALES];
    logic signed [BITS_PER_ELEM-1:0]  tap_q [NUM_SCALES][FIR_NUM_ELEM];
    logic signed [BITS_PER_ELEM-1:0]  tap_d [NUM_SCALES][FIR_NUM_ELEM];
    logic signed [SUM_TRUNCATION-1:0] wav_q [NUM_SCALES];
    logic signed [SUM_TRUNCATION-1:0] wav_d [NUM_SCALES];
    logic signed [ACC_BITS-1:0]       acc_q, acc_d;
    logic [NUM_SCALES-1:0]            cnt_q, cnt_d;
    logic [NUM_SCALES-1:0]            part_q, part_d;
    logic [SUM_TRUNCATION-1:0]        out_q, out_d;
    logic                             overrun_q, overrun_d;
    logic                             active_q, active_d;

    logic                             strobe;
    logic signed [BITS_PER_ELEM-1:0]  avg_now [NUM_SCALES];
    logic signed [RS_BITS-1:0]        avg_full;
    logic signed [BITS_PER_ELEM-1:0]  mac_tap;
    logic signed [7:0]                mac_coef;
    logic signed [PROD_BITS-1:0]      mac_prod;
    logic signed [ACC_BITS-1:0]       prod_ext;
    logic signed [ACC_BITS-1:0]       acc_shift;
    logic signed [SUM_TRUNCATION-1:0] sat_val;

    // sync_q[1] is the settled copy of i_data_clk, sync_q[2] its previous value
    assign strobe = sync_q[1] & ~sync_q[2];

    always_comb begin
        mac_tap  = '0;
        mac_coef = '0;
        for (int s = 0; s < NUM_SCALES; s++) begin
            for (int k = 0; k < FIR_NUM_ELEM; k++) begin
                if (scale_q == SCALE_IDX_BITS'(s) && tap_idx_q == TAP_IDX_BITS'(k)) begin
                    mac_tap = tap_q[s][k];
                end
            end
        end
        for (int k = 0; k < FIR_NUM_ELEM; k++) begin
            if (tap_idx_q == TAP_IDX_BITS'(k)) begin
                mac_coef = FILTER_VAL[8*k +: 8];
            end
        end
        mac_prod = mac_tap * mac_coef;
        prod_ext = {{(ACC_BITS - PROD_BITS){mac_prod[PROD_BITS-1]}}, mac_prod};

        acc_shift = acc_q >>> FIR_SHIFT;
        if (acc_shift > SAT_MAX) begin
            sat_val = SAT_MAX[SUM_TRUNCATION-1:0];
        end else if (acc_shift < SAT_MIN) begin
            sat_val = SAT_MIN[SUM_TRUNCATION-1:0];
        end else begin
            sat_val = acc_shift[SUM_TRUNCATION-1:0];
        end
    end

    always_comb begin
        sync_d    = {sync_q[1:0], bus.i_data_clk};
        state_d   = state_q;
        scale_d   = scale_q;
        tap_idx_d = tap_idx_q;
        sample_d  = sample_q;
        hist_d    = hist_q;
        rs_d      = rs_q;
        avg_d     = avg_q;
        avg_now   = avg_q;
        avg_full  = '0;
        tap_d     = tap_q;
        wav_d     = wav_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        part_d    = part_q;
        overrun_d = overrun_q;
        active_d  = 1'b1;

        // A strobe that lands mid-computation is discarded, only flagged
        if (strobe && state_q != ST_IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    sample_d = bus.i_value;
                    state_d  = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                hist_d[0] = sample_q;
                for (int k = 1; k < HIST_LEN; k++) begin
                    hist_d[k] = hist_q[k-1];
                end
                for (int s = 0; s < NUM_SCALES; s++) begin
                    rs_d[s] = rs_q[s]
                            + {{(RS_BITS - BITS_PER_ELEM){sample_q[BITS_PER_ELEM-1]}}, sample_q}
                            - {{(RS_BITS - BITS_PER_ELEM){hist_q[(2 ** (s + 1)) - 1][BITS_PER_ELEM-1]}},
                               hist_q[(2 ** (s + 1)) - 1]};
                    avg_full   = rs_d[s] >>> (s + 1);
                    avg_now[s] = avg_full[BITS_PER_ELEM-1:0];
                    if (bus.i_enable_mask[s]) begin
                        avg_d[s] = avg_now[s];
                    end
                    part_d[s] = bus.i_enable_mask[s] &
                                (~bus.i_decimate | ((cnt_q & NUM_SCALES'((1 << s) - 1)) == '0));
                    if (part_d[s]) begin
                        tap_d[s][0] = avg_now[s];
                        for (int k = 1; k < FIR_NUM_ELEM; k++) begin
                            tap_d[s][k] = tap_q[s][k-1];
                        end
                    end
                end
                cnt_d     = cnt_q + 1'b1;
                scale_d   = '0;
                tap_idx_d = '0;
                state_d   = part_d[0] ? ST_MAC : ST_SKIP;
            end
            ST_MAC: begin
                acc_d = prod_ext;
                if (tap_idx_q != '0) begin
                    acc_d = acc_q + prod_ext;
                end
                if (tap_idx_q == LAST_TAP) begin
                    state_d = ST_STORE;
                end else begin
                    tap_idx_d = tap_idx_q + 1'b1;
                end
            end
            ST_STORE, ST_SKIP: begin
                if (state_q == ST_STORE) begin
                    wav_d[scale_q] = sat_val;
                end
                if (scale_q == LAST_SCALE) begin
                    state_d = ST_DONE;
                end else begin
                    scale_d   = scale_q + 1'b1;
                    tap_idx_d = '0;
                    state_d   = part_q[scale_d] ? ST_MAC : ST_SKIP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Channels 0..N-1 are wavelet results, N..2N-1 the averages, anything else reads zero
        out_d = '0;
        for (int s = 0; s < NUM_SCALES; s++) begin
            if (bus.i_select_output_channel == 8'(s)) begin
                out_d = wav_q[s];
            end
            if (bus.i_select_output_channel == 8'(s + NUM_SCALES)) begin
                out_d = SUM_TRUNCATION'(avg_q[s]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            state_q   <= ST_IDLE;
            scale_q   <= '0;
            tap_idx_q <= '0;
            sample_q  <= '0;
            for (int k = 0; k < HIST_LEN; k++) begin
                hist_q[k] <= '0;
            end
            for (int s = 0; s < NUM_SCALES; s++) begin
                rs_q[s]  <= '0;
                avg_q[s] <= '0;
                wav_q[s] <= '0;
                for (int k = 0; k < FIR_NUM_ELEM; k++) begin
                    tap_q[s][k] <= '0;
                end
            end
            acc_q     <= '0;
            cnt_q     <= '0;
            part_q    <= '0;
            out_q     <= '0;
            overrun_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            scale_q   <= scale_d;
            tap_idx_q <= tap_idx_d;
            sample_q  <= sample_d;
            hist_q    <= hist_d;
            rs_q      <= rs_d;
            avg_q     <= avg_d;
            tap_q     <= tap_d;
            wav_q     <= wav_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            part_q    <= part_d;
            out_q     <= out_d;
            overrun_q <= overrun_d;
            active_q  <= active_d;
        end
    end

    assign bus.o_multiplexed_wavelet_out = out_q;
    assign bus.o_valid                   = (state_q == ST_DONE);
    assign bus.o_busy                    = (state_q != ST_IDLE);
    assign bus.o_overrun                 = overrun_q;
    assign bus.o_active                  = active_q;
endmodule
